// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retire of out-of-order results gathered from NUM_CDB broadcast channels.
// Optional macro ROB_CDB_BYPASS_EN lets operand lookups see same-cycle CDB results.
module reorder_buffer #(
    parameter int DEPTH   = 16,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int NUM_CDB = 2,
    parameter int XLEN    = 32,
    parameter int REG_W   = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [1:0]               issue_kind,
    input  logic                     issue_done,
    input  logic [XLEN-1:0]          issue_value,
    input  logic [REG_W-1:0]         issue_rd,
    input  logic                     issue_pred_taken,
    input  logic [XLEN-1:0]          issue_alt_pc,
    output logic [IDX_W-1:0]         issue_tag,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*IDX_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
    input  logic [IDX_W-1:0]         q1_tag,
    input  logic [IDX_W-1:0]         q2_tag,
    output logic                     q1_ready,
    output logic                     q2_ready,
    output logic [XLEN-1:0]          q1_value,
    output logic [XLEN-1:0]          q2_value,
    output logic                     commit_valid,
    output logic                     commit_wb,
    output logic                     commit_store,
    output logic [IDX_W-1:0]         commit_tag,
    output logic [REG_W-1:0]         commit_rd,
    output logic [XLEN-1:0]          commit_value,
    output logic                     flush_out,
    output logic [XLEN-1:0]          flush_pc,
    output logic [IDX_W:0]           count,
    output logic                     empty
);
    localparam logic [1:0] K_REG = 2'd0, K_STORE = 2'd1, K_BRANCH = 2'd2;
    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0]       r_busy, r_done, r_pred;
    logic [1:0]             r_kind  [DEPTH];
    logic [REG_W-1:0]       r_rd    [DEPTH];
    logic [XLEN-1:0]        r_value [DEPTH];
    logic [XLEN-1:0]        r_alt   [DEPTH];
    logic [IDX_W-1:0]       r_head, r_tail;
    logic [IDX_W:0]         r_count;

    logic [NUM_CDB-1:0][IDX_W-1:0] w_ctag;
    logic [NUM_CDB-1:0][XLEN-1:0]  w_cval;
    logic                          w_head_rdy, w_flush, w_commit, w_issue;
    logic [1:0][IDX_W-1:0]         w_qt;
    logic [1:0]                    w_qr;
    logic [1:0][XLEN-1:0]          w_qv;

    assign w_ctag = cdb_tag;
    assign w_cval = cdb_value;

    assign w_head_rdy = r_busy[r_head] && r_done[r_head] && rdy_in;
    assign w_flush    = w_head_rdy && (r_kind[r_head] == K_BRANCH) &&
                        (r_value[r_head][0] != r_pred[r_head]);
    assign w_commit   = w_head_rdy && !w_flush;
    assign w_issue    = issue_valid && issue_ready && rdy_in && !w_flush;

    assign issue_ready  = (r_count < FULL);
    assign issue_tag    = r_tail;
    assign count        = r_count;
    assign empty        = (r_count == '0);
    assign commit_valid = w_commit;
    assign commit_wb    = w_commit && (r_kind[r_head] == K_REG);
    assign commit_store = w_commit && (r_kind[r_head] == K_STORE);
    assign commit_tag   = r_head;
    assign commit_rd    = w_commit ? r_rd[r_head] : '0;
    assign commit_value = w_commit ? r_value[r_head] : '0;
    assign flush_out    = w_flush;
    assign flush_pc     = w_flush ? r_alt[r_head] : '0;

    assign w_qt = {q2_tag, q1_tag};
    always_comb begin
        w_qr = '0;
        w_qv = '0;
        for (int p = 0; p < 2; p++) begin
            w_qr[p] = r_busy[w_qt[p]] && r_done[w_qt[p]];
            w_qv[p] = w_qr[p] ? r_value[w_qt[p]] : '0;
`ifdef ROB_CDB_BYPASS_EN
            // Stored value wins; among channels the lowest index wins (scan high to low).
            if (!w_qr[p] && r_busy[w_qt[p]]) begin
                for (int i = NUM_CDB-1; i >= 0; i--) begin
                    if (cdb_valid[i] && (w_ctag[i] == w_qt[p])) begin
                        w_qr[p] = 1'b1;
                        w_qv[p] = w_cval[i];
                    end
                end
            end
`endif
        end
    end
    assign q1_ready = w_qr[0];
    assign q2_ready = w_qr[1];
    assign q1_value = w_qv[0];
    assign q2_value = w_qv[1];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_busy  <= '0;
            r_done  <= '0;
            r_pred  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_kind[e]  <= '0;
                r_rd[e]    <= '0;
                r_value[e] <= '0;
                r_alt[e]   <= '0;
            end
        end else if (rdy_in) begin
            if (w_flush) begin
                r_busy  <= '0;
                r_done  <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                // Descending scan so channel 0's write is the last one scheduled.
                for (int i = NUM_CDB-1; i >= 0; i--) begin
                    if (cdb_valid[i] && r_busy[w_ctag[i]] && !r_done[w_ctag[i]]) begin
                        r_value[w_ctag[i]] <= w_cval[i];
                        r_done[w_ctag[i]]  <= 1'b1;
                    end
                end
                if (w_issue) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_done[r_tail]  <= issue_done;
                    r_kind[r_tail]  <= issue_kind;
                    r_rd[r_tail]    <= issue_rd;
                    r_value[r_tail] <= issue_value;
                    r_pred[r_tail]  <= issue_pred_taken;
                    r_alt[r_tail]   <= issue_alt_pc;
                    r_tail          <= r_tail + 1'b1;
                end
                if (w_commit) begin
                    r_busy[r_head] <= 1'b0;
                    r_done[r_head] <= 1'b0;
                    r_head         <= r_head + 1'b1;
                end
                if (w_issue && !w_commit)
                    r_count <= r_count + 1'b1;
                else if (!w_issue && w_commit)
                    r_count <= r_count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_reorder_buffer;
    logic        clk_in = 0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_valid, issue_ready, issue_done, issue_pred_taken;
    logic [1:0]  issue_kind;
    logic [31:0] issue_value, issue_alt_pc;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_tag;
    logic [1:0]  cdb_valid;
    logic [3:0]  ct [2];
    logic [31:0] cv [2];
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_value;
    logic [3:0]  q1_tag, q2_tag;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic        commit_valid, commit_wb, commit_store;
    logic [3:0]  commit_tag;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic        flush_out;
    logic [31:0] flush_pc;
    logic [4:0]  count;
    logic        empty;

    assign cdb_tag   = {ct[1], ct[0]};
    assign cdb_value = {cv[1], cv[0]};

    always #5 clk_in = ~clk_in;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_kind(issue_kind),
        .issue_done(issue_done), .issue_value(issue_value), .issue_rd(issue_rd),
        .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc), .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_value(q1_value), .q2_value(q2_value),
        .commit_valid(commit_valid), .commit_wb(commit_wb), .commit_store(commit_store),
        .commit_tag(commit_tag), .commit_rd(commit_rd), .commit_value(commit_value),
        .flush_out(flush_out), .flush_pc(flush_pc), .count(count), .empty(empty)
    );

    typedef struct {
        int          tag;
        int          kind;
        bit          done;
        logic [31:0] value;
        logic [4:0]  rd;
        bit          pred;
        logic [31:0] alt;
    } ent_t;

    ent_t q[$];          // in-flight instructions in program order
    int   m_tail = 0;
    bit   e_mis, e_cv, e_room;
    int   n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", name, obs, exp);
        end
    endtask

    function automatic void look(input int t, output bit r, output logic [31:0] v);
        r = 0;
        v = 0;
        foreach (q[j]) begin
            if (q[j].tag == t) begin
                if (q[j].done) begin
                    r = 1;
                    v = q[j].value;
                end
`ifdef ROB_CDB_BYPASS_EN
                else begin
                    for (int ch = 0; ch < 2; ch++)
                        if (!r && cdb_valid[ch] && ct[ch] == t) begin
                            r = 1;
                            v = cv[ch];
                        end
                end
`endif
            end
        end
    endfunction

    task automatic check_outputs();
        int          sz;
        bit          hrdy, r;
        logic [31:0] v;
        sz     = q.size();
        e_room = (sz < 16);
        hrdy   = rdy_in && sz > 0 && q[0].done;
        e_mis  = hrdy && q[0].kind == 2 && (q[0].value[0] != q[0].pred);
        e_cv   = hrdy && !e_mis;
        chk("issue_ready", issue_ready, e_room);
        chk("issue_tag", issue_tag, m_tail);
        chk("count", count, sz);
        chk("empty", empty, sz == 0);
        chk("commit_valid", commit_valid, e_cv);
        chk("commit_wb", commit_wb, e_cv && q[0].kind == 0);
        chk("commit_store", commit_store, e_cv && q[0].kind == 1);
        chk("commit_tag", commit_tag, (m_tail - sz + 16) % 16);
        chk("commit_rd", commit_rd, e_cv ? q[0].rd : 5'd0);
        chk("commit_value", commit_value, e_cv ? q[0].value : 32'd0);
        chk("flush_out", flush_out, e_mis);
        chk("flush_pc", flush_pc, e_mis ? q[0].alt : 32'd0);
        look(q1_tag, r, v);
        chk("q1_ready", q1_ready, r);
        chk("q1_value", q1_value, v);
        look(q2_tag, r, v);
        chk("q2_ready", q2_ready, r);
        chk("q2_value", q2_value, v);
    endtask

    task automatic model_update();
        ent_t e;
        if (!rdy_in) return;
        if (e_mis) begin
            q.delete();
            m_tail = 0;
            return;
        end
        for (int ch = 0; ch < 2; ch++)
            if (cdb_valid[ch])
                foreach (q[j])
                    if (q[j].tag == ct[ch] && !q[j].done) begin
                        q[j].done  = 1;
                        q[j].value = cv[ch];
                    end
        if (e_cv) void'(q.pop_front());
        if (issue_valid && e_room) begin
            e.tag = m_tail; e.kind = issue_kind; e.done = issue_done; e.value = issue_value;
            e.rd = issue_rd; e.pred = issue_pred_taken; e.alt = issue_alt_pc;
            q.push_back(e);
            m_tail = (m_tail + 1) % 16;
        end
    endtask

    // Called just after a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle();
        #1;
        check_outputs();
        model_update();
        @(negedge clk_in);
    endtask

    task automatic idle();
        rdy_in = 1; issue_valid = 0; issue_kind = 0; issue_done = 0; issue_value = 0;
        issue_rd = 0; issue_pred_taken = 0; issue_alt_pc = 0; cdb_valid = 0;
        ct[0] = 0; ct[1] = 0; cv[0] = 0; cv[1] = 0;
    endtask

    task automatic iss(input int kind, input bit dn, input logic [31:0] val, input logic [4:0] rd,
                       input bit pred, input logic [31:0] alt);
        issue_valid = 1; issue_kind = 2'(kind); issue_done = dn; issue_value = val;
        issue_rd = rd; issue_pred_taken = pred; issue_alt_pc = alt;
    endtask

    task automatic cdb(input int ch, input int tag, input logic [31:0] val);
        cdb_valid[ch] = 1; ct[ch] = 4'(tag); cv[ch] = val;
    endtask

    initial begin
        rst_in = 0; idle(); q1_tag = 0; q2_tag = 0;
        #3;
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_issue_tag", issue_tag, 0);
        chk("rst_commit_valid", commit_valid, 0);
        @(negedge clk_in); rst_in = 1;

        // Fill all 16 entries, then retire tag 0 via the CDB.
        for (int i = 0; i < 16; i++) begin
            idle(); iss(0, 0, 0, 5'(i + 1), 0, 0); cycle();
        end
        idle(); #1;
        chk("full_issue_ready", issue_ready, 0);
        chk("full_count", count, 16);
        cdb(0, 0, 32'h55); cycle();
        idle(); #1;
        chk("fill_commit_valid", commit_valid, 1);
        chk("fill_commit_value", commit_value, 32'h55);
        chk("fill_commit_tag", commit_tag, 0);
        chk("fill_ready_same", issue_ready, 0);
        cycle();
        #1 chk("fill_ready_after", issue_ready, 1);
        // Complete out of order (high tags first), then drain.
        for (int t = 15; t >= 1; t -= 2) begin
            idle(); cdb(0, t, 32'h100 + t); if (t > 1) cdb(1, t - 1, 32'h100 + t - 1); cycle();
        end
        idle();
        for (int i = 0; i < 16; i++) cycle();
        #1 chk("drain_empty", empty, 1);

        // Dual-CDB collision on tag 3, then a broadcast to a freed tag.
        for (int i = 0; i < 4; i++) begin idle(); iss(0, 0, 0, 5'(i), 0, 0); cycle(); end
        idle(); cdb(0, 3, 32'hA); cdb(1, 3, 32'hB); cycle();
        idle(); q1_tag = 3; #1;
        chk("collide_ready", q1_ready, 1);
        chk("collide_value", q1_value, 32'hA);
        cycle();
        idle(); cdb(0, 0, 1); cdb(1, 1, 2); cycle();
        idle(); cdb(0, 2, 3); cycle();
        idle(); for (int i = 0; i < 5; i++) cycle();
        idle(); cdb(0, 3, 32'h99); cycle();
        idle(); #1;
        chk("freed_count", count, 0);
        chk("freed_q1_ready", q1_ready, 0);
        cycle();

        // Mispredicted branch at head with younger entries behind it.
        idle(); iss(2, 0, 0, 0, 1, 32'h1004); cycle();
        for (int i = 0; i < 3; i++) begin idle(); iss(0, 0, 0, 5'(i), 0, 0); cycle(); end
        idle(); cdb(0, 4, 0); cycle();
        idle(); iss(0, 1, 32'hDEAD, 1, 0, 0); cdb(0, 5, 32'h7); #1;
        chk("mis_flush", flush_out, 1);
        chk("mis_flush_pc", flush_pc, 32'h1004);
        chk("mis_commit", commit_valid, 0);
        cycle();
        idle(); #1;
        chk("post_flush", flush_out, 0);
        chk("post_count", count, 0);
        chk("post_empty", empty, 1);
        chk("post_tag", issue_tag, 0);
        chk("post_ready", issue_ready, 1);
        cycle();

        // Lookup of a tag being broadcast in the same cycle.
        for (int i = 0; i < 6; i++) begin idle(); iss(0, 0, 0, 5'(i), 0, 0); cycle(); end
        idle(); q1_tag = 5; cdb(0, 5, 32'h77); #1;
`ifdef ROB_CDB_BYPASS_EN
        chk("byp_ready", q1_ready, 1);
        chk("byp_value", q1_value, 32'h77);
`else
        chk("byp_ready", q1_ready, 0);
        chk("byp_value", q1_value, 0);
`endif
        cycle();
        idle(); #1;
        chk("byp_next_ready", q1_ready, 1);
        chk("byp_next_value", q1_value, 32'h77);
        cycle();

        // Pause with the head done: nothing moves.
        idle(); cdb(0, 0, 32'h12); cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); rdy_in = 0; iss(0, 0, 0, 0, 0, 0); cdb(0, 1, 32'h34); cycle();
        end
        idle(); #1;
        chk("pause_count", count, 6);
        chk("resume_commit", commit_valid, 1);
        cycle();

        // Random traffic.
        for (int c = 0; c < 500; c++) begin
            int k;
            idle();
            rdy_in = ($urandom_range(9) != 0);
            k = $urandom_range(9);
            if ($urandom_range(3) != 0)
                iss(k < 6 ? 0 : k < 8 ? 1 : k == 8 ? 2 : 3, $urandom_range(3) == 0, $urandom,
                    5'($urandom), 1'($urandom_range(1)), $urandom);
            for (int ch = 0; ch < 2; ch++)
                if ($urandom_range(1) == 1)
                    cdb(ch, q.size() > 0 ? q[$urandom_range(q.size() - 1)].tag : $urandom_range(15),
                        $urandom);
            q1_tag = 4'($urandom_range(15));
            q2_tag = 4'($urandom_range(15));
            cycle();
        end

        // Asynchronous reset in the middle of a cycle with entries in flight.
        for (int i = 0; i < 3; i++) begin idle(); iss(0, 1, 32'h5, 5'(i), 0, 0); cycle(); end
        idle(); q1_tag = 4'(m_tail); q2_tag = 4'((m_tail + 15) % 16);
        #3 rst_in = 0;
        #1;
        chk("arst_issue_ready", issue_ready, 1);
        chk("arst_empty", empty, 1);
        chk("arst_count", count, 0);
        chk("arst_issue_tag", issue_tag, 0);
        chk("arst_commit_valid", commit_valid, 0);
        chk("arst_commit_value", commit_value, 0);
        chk("arst_flush", flush_out, 0);
        chk("arst_q2_ready", q2_ready, 0);
        chk("arst_q2_value", q2_value, 0);
        q.delete(); m_tail = 0;
        @(negedge clk_in); rst_in = 1;
        idle(); iss(0, 1, 32'h9, 3, 0, 0); cycle();
        idle(); cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
